// File: rtl/ds_fifo.sv
// ds_fifo: direct-sound sample FIFO; assembles halfword/word writes into 32-bit words, first-word fall-through head
// Ports: clock/reset (sync, active-high); wr_en/wr_strb/wr_data register writes (strb bit0 = low half, bit1 = high half);
//        FIFO_re pop, FIFO_clr flush; FIFO_val head word (0 when empty), FIFO_size fill level;
//        overflow/underflow one-cycle pulses for a dropped push / pop while empty.
module ds_fifo #(
  parameter int DEPTH  = 8,
  parameter int SIZE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_strb,
  input  logic [31:0]       wr_data,
  input  logic              FIFO_re,
  input  logic              FIFO_clr,
  output logic [31:0]       FIFO_val,
  output logic [SIZE_W-1:0] FIFO_size,
  output logic              overflow,
  output logic              underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [SIZE_W-1:0] count_q, count_d;
  logic [15:0]       stage_q, stage_d;
  logic              ovf_q, unf_q, push_req, pop_ok, push_ok, full;
  logic [31:0]       push_word;
  always_comb begin
    push_req  = wr_en & wr_strb[1];
    push_word = wr_strb[0] ? wr_data : {wr_data[31:16], stage_q};
    full      = count_q == SIZE_W'(DEPTH);
    pop_ok    = FIFO_re && count_q != '0;
    // a full FIFO still takes a push when the head is leaving in the same cycle
    push_ok   = push_req && (!full || pop_ok);
    count_d   = count_q + SIZE_W'(push_ok) - SIZE_W'(pop_ok);
    stage_d   = (wr_en && wr_strb == 2'b01) ? wr_data[15:0] : push_req ? 16'h0 : stage_q;
  end
  always_ff @(posedge clock) begin
    if (reset || FIFO_clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stage_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      wr_ptr_q <= wr_ptr_q + AW'(push_ok);
      count_q  <= count_d;
      stage_q  <= stage_d;
      ovf_q    <= push_req && !push_ok;
      unf_q    <= FIFO_re && count_q == '0;
    end
  end
  always_ff @(posedge clock)
    if (!reset && !FIFO_clr && push_ok) mem[wr_ptr_q] <= push_word;
  assign FIFO_val  = count_q == '0 ? 32'h0 : mem[rd_ptr_q];
  assign FIFO_size = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule
